// File: rtl/niosii_usb_onchip_memory_arbiter_pkg.sv
// Shared definitions for the two-master on-chip RAM arbiter and any other
// shared slave that reuses the round-robin grant block.
package niosii_usb_onchip_memory_arbiter_pkg;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  // Identifies which master owns a grant or an in-flight read
  typedef enum logic {
    MASTER_0 = 1'b0,
    MASTER_1 = 1'b1
  } master_id_t;

  // One stage of the read-return tracking pipe
  typedef struct packed {
    logic       valid;
    master_id_t owner;
  } rd_track_t;

  // Round-robin pick between two requesters; with both requesting, the
  // master that did not win last time gets the slot.
  function automatic master_id_t rr_winner(input logic [1:0] req,
                                           input master_id_t last);
    master_id_t win;
    if (req == 2'b11) begin
      if (last == MASTER_1) win = MASTER_0;
      else                  win = MASTER_1;
    end else if (req[1]) begin
      win = MASTER_1;
    end else begin
      win = MASTER_0;
    end
    return win;
  endfunction

endpackage

// File: rtl/niosii_usb_onchip_memory_arbiter_rr_grant2.sv
// Two-request round-robin grant. Grant is combinational within the cycle;
// only the identity of the last winner is registered.
module niosii_usb_onchip_memory_arbiter_rr_grant2
  import niosii_usb_onchip_memory_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] i_req,
  output logic [1:0] o_grant,
  output master_id_t o_grant_id,
  output logic       o_grant_valid
);

  master_id_t r_lastGrant;

  // Pick this cycle's winner; nothing is granted while reset is held
  always_comb begin
    o_grant       = 2'b00;
    o_grant_id    = MASTER_0;
    o_grant_valid = 1'b0;
    if (reset_n && (i_req != 2'b00)) begin
      o_grant_valid = 1'b1;
      o_grant_id    = rr_winner(i_req, r_lastGrant);
      o_grant       = (o_grant_id == MASTER_1) ? 2'b10 : 2'b01;
    end
  end

  // Remember the last winner; starting at master 1 lets master 0 win the first contention
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lastGrant <= MASTER_1;
    end else if (o_grant_valid) begin
      r_lastGrant <= o_grant_id;
    end
  end

endmodule

// File: rtl/niosii_usb_onchip_memory_arbiter.sv
// Arbiter placing the Nios II data master (m0) and the USB DMA master (m1)
// in front of the single-port 8192x32 on-chip RAM. Holds the command mux,
// the read-return tracking pipe and the response demux.
module niosii_usb_onchip_memory_arbiter
  import niosii_usb_onchip_memory_arbiter_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  logic [1:0]        w_req;
  logic [1:0]        w_grant;
  master_id_t        w_grantId;
  logic              w_grantValid;
  logic [ADDR_W-1:0] w_selAddr;
  logic [BE_W-1:0]   w_selBe;
  logic [DATA_W-1:0] w_selData;
  logic              w_selWrite;
  rd_track_t         w_issue;
  rd_track_t         w_lastStage;

  logic [ADDR_W-1:0] r_holdAddr;
  logic [BE_W-1:0]   r_holdBe;
  logic [DATA_W-1:0] r_holdData;
  rd_track_t [READ_LATENCY-1:0] r_pipe;

  // A read+write from the same master is treated as a write, but both count as a request
  assign w_req = {m1_read | m1_write, m0_read | m0_write};

  niosii_usb_onchip_memory_arbiter_rr_grant2 u_grant (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_req         (w_req),
    .o_grant       (w_grant),
    .o_grant_id    (w_grantId),
    .o_grant_valid (w_grantValid)
  );

  // Stall a requester only when it lost this cycle (zero-wait when uncontended)
  assign m0_waitrequest = w_req[0] & ~w_grant[0];
  assign m1_waitrequest = w_req[1] & ~w_grant[1];

  // Select the command fields of whichever master owns this cycle
  always_comb begin
    w_selAddr  = m0_address;
    w_selBe    = m0_byteenable;
    w_selData  = m0_writedata;
    w_selWrite = m0_write;
    if (w_grantId == MASTER_1) begin
      w_selAddr  = m1_address;
      w_selBe    = m1_byteenable;
      w_selData  = m1_writedata;
      w_selWrite = m1_write;
    end
  end

  // Keep address/lanes/data stable on idle cycles to avoid needless RAM pin toggling
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_holdAddr <= '0;
      r_holdBe   <= '0;
      r_holdData <= '0;
    end else if (w_grantValid) begin
      r_holdAddr <= w_selAddr;
      r_holdBe   <= w_selBe;
      r_holdData <= w_selData;
    end
  end

  assign mem_address    = w_grantValid ? w_selAddr : r_holdAddr;
  assign mem_byteenable = w_grantValid ? w_selBe   : r_holdBe;
  assign mem_writedata  = w_grantValid ? w_selData : r_holdData;
  assign mem_chipselect = w_grantValid;
  assign mem_write      = w_grantValid & w_selWrite;
  assign mem_clken      = reset_n;

  // Describe the read being issued this cycle (if any) for the tracking pipe
  always_comb begin
    w_issue.valid = w_grantValid & ~w_selWrite;
    w_issue.owner = w_grantId;
  end

  // Delay each issued read by the RAM latency so its owner tag lines up with q
  if (READ_LATENCY == 1) begin : g_lat1
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_pipe <= '0;
      end else begin
        r_pipe[0] <= w_issue;
      end
    end
  end else begin : g_latN
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_pipe <= '0;
      end else begin
        r_pipe <= {r_pipe[READ_LATENCY-2:0], w_issue};
      end
    end
  end

  assign w_lastStage = r_pipe[READ_LATENCY-1];

  // RAM q is shared by both masters; the valid strobe steers ownership
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  assign m0_readdatavalid = w_lastStage.valid & (w_lastStage.owner == MASTER_0);
  assign m1_readdatavalid = w_lastStage.valid & (w_lastStage.owner == MASTER_1);

endmodule

// File: tb/tb_niosii_usb_onchip_memory_arbiter.sv
// Bench for the on-chip RAM arbiter. Two arbiters (read latency 1 and 2)
// share the same master stimulus, each in front of its own RAM model.
// A shadow memory and grant model predict every command-side output, and
// expected read returns are queued per arbiter with the cycle they are due.
module tb_niosii_usb_onchip_memory_arbiter;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [12:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } cmd_t;

  typedef struct {
    int          owner;
    logic [31:0] data;
    int          due;
  } rdExp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [12:0] m0_address = '0;
  logic [3:0]  m0_byteenable = '0;
  logic        m0_read = 1'b0;
  logic        m0_write = 1'b0;
  logic [31:0] m0_writedata = '0;
  logic [12:0] m1_address = '0;
  logic [3:0]  m1_byteenable = '0;
  logic        m1_read = 1'b0;
  logic        m1_write = 1'b0;
  logic [31:0] m1_writedata = '0;

  logic        wait0 [2];
  logic        wait1 [2];
  logic        rdv0 [2];
  logic        rdv1 [2];
  logic [31:0] rdd0 [2];
  logic [31:0] rdd1 [2];
  logic [12:0] memAddr [2];
  logic [3:0]  memBe [2];
  logic        cs [2];
  logic        memWr [2];
  logic [31:0] memWd [2];
  logic        clken [2];
  logic [31:0] memRd [2];

  logic [31:0] ram [2][8192];
  logic [31:0] ramQ1 [2];
  logic [31:0] ramQ2 [2];
  logic [31:0] shadow [8192];

  rdExp_t expQ0[$];
  rdExp_t expQ1[$];

  int checkCount = 0;
  int errorCount = 0;
  int cycleCnt = 0;
  int lastGrantModel = 1;
  bit monitorOn = 1'b0;

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  // Cycle index used to time-stamp expected read returns
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  niosii_usb_onchip_memory_arbiter #(.READ_LATENCY(1)) dutLat1 (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(wait0[0]),
    .m0_readdata(rdd0[0]), .m0_readdatavalid(rdv0[0]),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(wait1[0]),
    .m1_readdata(rdd1[0]), .m1_readdatavalid(rdv1[0]),
    .mem_address(memAddr[0]), .mem_byteenable(memBe[0]), .mem_chipselect(cs[0]),
    .mem_write(memWr[0]), .mem_writedata(memWd[0]), .mem_clken(clken[0]),
    .mem_readdata(memRd[0])
  );

  niosii_usb_onchip_memory_arbiter #(.READ_LATENCY(2)) dutLat2 (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(wait0[1]),
    .m0_readdata(rdd0[1]), .m0_readdatavalid(rdv0[1]),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(wait1[1]),
    .m1_readdata(rdd1[1]), .m1_readdatavalid(rdv1[1]),
    .mem_address(memAddr[1]), .mem_byteenable(memBe[1]), .mem_chipselect(cs[1]),
    .mem_write(memWr[1]), .mem_writedata(memWd[1]), .mem_clken(clken[1]),
    .mem_readdata(memRd[1])
  );

  // RAM models: instance 0 has unregistered q (1 clock), instance 1 registered q (2 clocks)
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (clken[k] && cs[k]) begin
        if (memWr[k]) begin
          for (int b = 0; b < 4; b++)
            if (memBe[k][b]) ram[k][memAddr[k]][b*8 +: 8] <= memWd[k][b*8 +: 8];
        end else begin
          ramQ1[k] <= ram[k][memAddr[k]];
        end
      end
      ramQ2[k] <= ramQ1[k];
    end
  end

  assign memRd[0] = ramQ1[0];
  assign memRd[1] = ramQ2[1];

  // Count a comparison and report it when observed and expected differ
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  function automatic cmd_t idleCmd();
    cmd_t c;
    c = '0;
    return c;
  endfunction

  function automatic cmd_t rdCmd(input int a);
    cmd_t c;
    c = '0;
    c.rd = 1'b1;
    c.addr = a[12:0];
    c.be = 4'hF;
    return c;
  endfunction

  function automatic cmd_t wrCmd(input int a, input logic [3:0] be, input logic [31:0] d);
    cmd_t c;
    c = '0;
    c.wr = 1'b1;
    c.addr = a[12:0];
    c.be = be;
    c.data = d;
    return c;
  endfunction

  // Compare one arbiter's response side against the head of its expectation queue
  task automatic checkResponse(input int k);
    bit     hit;
    rdExp_t e;
    logic [31:0] dat;
    hit = 1'b0;
    if (k == 0) begin
      if (expQ0.size() > 0 && expQ0[0].due <= cycleCnt) begin e = expQ0.pop_front(); hit = 1'b1; end
    end else begin
      if (expQ1.size() > 0 && expQ1[0].due <= cycleCnt) begin e = expQ1.pop_front(); hit = 1'b1; end
    end
    if (hit) begin
      checkOutput($sformatf("rdvalid0 lat%0d c%0d", k + 1, cycleCnt), {31'b0, rdv0[k]}, {31'b0, e.owner == 0});
      checkOutput($sformatf("rdvalid1 lat%0d c%0d", k + 1, cycleCnt), {31'b0, rdv1[k]}, {31'b0, e.owner == 1});
      dat = (e.owner == 0) ? rdd0[k] : rdd1[k];
      checkOutput($sformatf("rddata m%0d lat%0d c%0d", e.owner, k + 1, cycleCnt), dat, e.data);
    end else begin
      checkOutput($sformatf("idle rdvalid0 lat%0d c%0d", k + 1, cycleCnt), {31'b0, rdv0[k]}, 32'd0);
      checkOutput($sformatf("idle rdvalid1 lat%0d c%0d", k + 1, cycleCnt), {31'b0, rdv1[k]}, 32'd0);
    end
  endtask

  // Watch the response side of both arbiters every cycle, away from the active edge
  always @(negedge clk) begin
    if (monitorOn) begin
      checkResponse(0);
      checkResponse(1);
    end
  end

  // Drive one cycle of master commands, check the command side, advance the model
  task automatic applyStimulus(input logic rstLevel, input cmd_t c0, input cmd_t c1, output int granted);
    logic   req0;
    logic   req1;
    int     g;
    cmd_t   gc;
    rdExp_t e;
    @(negedge clk);
    if (!rstLevel) begin
      expQ0.delete();
      expQ1.delete();
      lastGrantModel = 1;
    end
    reset_n = rstLevel;
    m0_read = c0.rd; m0_write = c0.wr; m0_address = c0.addr;
    m0_byteenable = c0.be; m0_writedata = c0.data;
    m1_read = c1.rd; m1_write = c1.wr; m1_address = c1.addr;
    m1_byteenable = c1.be; m1_writedata = c1.data;
    #1;
    req0 = c0.rd | c0.wr;
    req1 = c1.rd | c1.wr;
    g = -1;
    if (rstLevel) begin
      if (req0 && req1) g = (lastGrantModel == 1) ? 0 : 1;
      else if (req0)    g = 0;
      else if (req1)    g = 1;
    end
    gc = (g == 1) ? c1 : c0;
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("wait0 lat%0d c%0d", k + 1, cycleCnt), {31'b0, wait0[k]}, {31'b0, req0 && (g != 0)});
      checkOutput($sformatf("wait1 lat%0d c%0d", k + 1, cycleCnt), {31'b0, wait1[k]}, {31'b0, req1 && (g != 1)});
      checkOutput($sformatf("chipselect lat%0d c%0d", k + 1, cycleCnt), {31'b0, cs[k]}, {31'b0, g >= 0});
      checkOutput($sformatf("clken lat%0d c%0d", k + 1, cycleCnt), {31'b0, clken[k]}, {31'b0, rstLevel});
      if (g >= 0) begin
        checkOutput($sformatf("mem_write lat%0d c%0d", k + 1, cycleCnt), {31'b0, memWr[k]}, {31'b0, gc.wr});
        checkOutput($sformatf("mem_address lat%0d c%0d", k + 1, cycleCnt), {19'b0, memAddr[k]}, {19'b0, gc.addr});
        checkOutput($sformatf("mem_byteenable lat%0d c%0d", k + 1, cycleCnt), {28'b0, memBe[k]}, {28'b0, gc.be});
        if (gc.wr)
          checkOutput($sformatf("mem_writedata lat%0d c%0d", k + 1, cycleCnt), memWd[k], gc.data);
      end else begin
        checkOutput($sformatf("idle mem_write lat%0d c%0d", k + 1, cycleCnt), {31'b0, memWr[k]}, 32'd0);
      end
    end
    if (g >= 0) begin
      if (gc.wr) begin
        for (int b = 0; b < 4; b++)
          if (gc.be[b]) shadow[gc.addr][b*8 +: 8] = gc.data[b*8 +: 8];
      end else begin
        e.owner = g;
        e.data  = shadow[gc.addr];
        e.due   = cycleCnt + 1;
        expQ0.push_back(e);
        e.due   = cycleCnt + 2;
        expQ1.push_back(e);
      end
      lastGrantModel = g;
    end
    granted = g;
  endtask

  // Hard stop if the run ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run did not reach its summary");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main scenario sequence
  initial begin
    int g;
    int idx0;
    int idx1;
    monitorOn = 1'b1;

    // Reset state: no grants, no stalls without requests, RAM disabled
    applyStimulus(1'b0, idleCmd(), idleCmd(), g);
    applyStimulus(1'b0, idleCmd(), idleCmd(), g);

    // Lone m0 write is zero-wait, then a read of it returns one clock later
    applyStimulus(1'b1, wrCmd(32'h0010, 4'hF, 32'hDEADBEEF), idleCmd(), g);
    applyStimulus(1'b1, rdCmd(32'h0010), idleCmd(), g);
    applyStimulus(1'b1, idleCmd(), idleCmd(), g);

    // Preload data with single-master writes, alternating masters
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) applyStimulus(1'b1, wrCmd(32'h100 + i, 4'hF, 32'h1000_0000 + i * 32'h0101_0101), idleCmd(), g);
      else            applyStimulus(1'b1, idleCmd(), wrCmd(32'h100 + i, 4'hF, 32'h1000_0000 + i * 32'h0101_0101), g);
    end
    applyStimulus(1'b1, wrCmd(32'h0000, 4'hF, 32'h55AA_55AA), idleCmd(), g);
    applyStimulus(1'b1, idleCmd(), wrCmd(32'h0020, 4'hF, 32'hCAFE_0020), g);
    applyStimulus(1'b1, wrCmd(32'h0021, 4'hF, 32'hCAFE_0021), idleCmd(), g);

    // Fresh reset, then both masters read in the same cycle: m0 first, m1 next
    applyStimulus(1'b0, idleCmd(), idleCmd(), g);
    applyStimulus(1'b1, rdCmd(32'h0020), rdCmd(32'h0021), g);
    applyStimulus(1'b1, idleCmd(), rdCmd(32'h0021), g);
    applyStimulus(1'b1, idleCmd(), idleCmd(), g);
    applyStimulus(1'b1, idleCmd(), idleCmd(), g);

    // Continuous contention for 8 cycles: strict alternation, a return every cycle
    idx0 = 0;
    idx1 = 0;
    for (int n = 0; n < 8; n++) begin
      applyStimulus(1'b1, rdCmd(32'h100 + idx0), rdCmd(32'h104 + idx1), g);
      if (g == 0) idx0++;
      else if (g == 1) idx1++;
    end
    applyStimulus(1'b1, idleCmd(), idleCmd(), g);
    applyStimulus(1'b1, idleCmd(), idleCmd(), g);

    // Top-of-memory partial write, read back by the other master, and no wrap to 0x0000
    applyStimulus(1'b1, idleCmd(), wrCmd(32'h1FFF, 4'hF, 32'hFFFF_FFFF), g);
    applyStimulus(1'b1, idleCmd(), wrCmd(32'h1FFF, 4'h3, 32'h0000_A5A5), g);
    applyStimulus(1'b1, rdCmd(32'h1FFF), idleCmd(), g);
    applyStimulus(1'b1, rdCmd(32'h0000), idleCmd(), g);
    applyStimulus(1'b1, idleCmd(), idleCmd(), g);
    applyStimulus(1'b1, idleCmd(), idleCmd(), g);

    // Read and write asserted together behave as a write with no read return
    applyStimulus(1'b1, '{rd: 1'b1, wr: 1'b1, addr: 13'h0200, be: 4'hF, data: 32'h1234_5678}, idleCmd(), g);
    applyStimulus(1'b1, idleCmd(), rdCmd(32'h0200), g);
    applyStimulus(1'b1, idleCmd(), idleCmd(), g);
    applyStimulus(1'b1, idleCmd(), idleCmd(), g);

    // Reset right after a granted read: the in-flight return is dropped
    applyStimulus(1'b1, rdCmd(32'h0101), idleCmd(), g);
    @(posedge clk);
    reset_n = 1'b0;
    expQ0.delete();
    expQ1.delete();
    lastGrantModel = 1;
    applyStimulus(1'b0, rdCmd(32'h0102), rdCmd(32'h0106), g);
    applyStimulus(1'b0, rdCmd(32'h0102), rdCmd(32'h0106), g);
    applyStimulus(1'b1, rdCmd(32'h0102), rdCmd(32'h0106), g);
    applyStimulus(1'b1, idleCmd(), rdCmd(32'h0106), g);

    // Let every outstanding return drain, then confirm nothing is left pending
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, idleCmd(), idleCmd(), g);
    checkOutput("drain queue lat1", expQ0.size(), 32'd0);
    checkOutput("drain queue lat2", expQ1.size(), 32'd0);

    monitorOn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
